alu_operand_loader: RTL and testbench

- Upstream stage of the 3-bit ALU board top.
- Turns a single shared 3-switch bank plus one raw push-button into registered A, B and S operands, so the ALU needs only 3 switches instead of 9.
- Debounces the button, then steps an FSM: capture A, capture B, capture S, show result.
- Presents stable operands, a valid flag and a stage indicator to the ALU/LED logic.

---
 rtl/alu_loader_pkg.sv | 15 +
 rtl/alu_operand_loader_btn_debounce.sv | 94 +++++++++
 rtl/alu_operand_loader.sv | 112 +++++++++++
 tb/tb_alu_operand_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_loader_pkg.sv
// Shared definitions for the ALU operand loader.
// Holds the loader state encoding. The encoding is also what drives
// the stage LEDs, so the numeric values matter.
package alu_loader_pkg;

  localparam int STAGE_W = 2;

  typedef enum logic [STAGE_W-1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    LOAD_S = 2'd2,
    SHOW   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_operand_loader_btn_debounce.sv
// Push-button conditioner for the operand loader.
// Synchronizes the raw active-low button and debounces it. It emits a
// single-cycle press pulse when the debounced level goes from released
// to pressed.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   btn_n  - raw button, active-low, bouncy, asynchronous to clk
//   press  - one-cycle pulse per accepted press
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             btn_s1_q, btn_s1_d;
  logic             btn_s2_q, btn_s2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed_q, armed_d;
  logic [1:0]       prime_q, prime_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] arm_cnt_inc;

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign arm_cnt_inc = arm_cnt_q + CNT_W'(1);

  always_comb begin
    btn_s1_d  = btn_n;
    btn_s2_d  = btn_s1_q;
    prime_d   = {prime_q[0], 1'b1};
    level_d   = level_q;
    cnt_d     = '0;
    armed_d   = armed_q;
    arm_cnt_d = '0;

    // Level debounce: count consecutive cycles that disagree with the
    // accepted level; any agreeing cycle restarts the count.
    if (btn_s2_q != level_q) begin
      if (cnt_inc == CNT_MAX) begin
        level_d = btn_s2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end

    // After reset, presses are ignored until the button has been seen
    // released for a full debounce window. prime_q masks the cycles where
    // the synchronizer still holds its reset value instead of the pin.
    // This keeps a button held through reset from counting as a press.
    if (!armed_q && prime_q[1] && btn_s2_q) begin
      if (arm_cnt_inc == CNT_MAX) begin
        armed_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_inc;
      end
    end

    press_d = armed_q & level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q  <= 1'b1;
      btn_s2_q  <= 1'b1;
      level_q   <= 1'b1;
      cnt_q     <= '0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      prime_q   <= 2'b00;
      press_q   <= 1'b0;
    end else begin
      btn_s1_q  <= btn_s1_d;
      btn_s2_q  <= btn_s2_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
      prime_q   <= prime_d;
      press_q   <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// ALU operand loader.
// Uses one shared switch bank and one push-button to load three
// registered operands (A, B, select). Each debounced press steps the
// loader through LOAD_A -> LOAD_B -> LOAD_S -> SHOW -> LOAD_A.
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   sw        - raw slide switches, asynchronous to clk
//   btn_n     - raw push-button, active-low
//   a_q       - operand A
//   b_q       - operand B
//   s_q       - ALU select
//   op_valid  - high while in SHOW
//   load_done - one-cycle pulse on entry to SHOW
//   stage     - current state encoding for LEDs
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   sw,
  input  logic               btn_n,
  output logic [WIDTH-1:0]   a_q,
  output logic [WIDTH-1:0]   b_q,
  output logic [WIDTH-1:0]   s_q,
  output logic               op_valid,
  output logic               load_done,
  output logic [STAGE_W-1:0] stage
);

  logic             press;
  logic [WIDTH-1:0] sw_s1_q, sw_s2_q;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_d, b_d, s_d;
  logic             op_valid_q, op_valid_d;
  logic             load_done_q, load_done_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_n),
    .press (press)
  );

  // The switches are captured only from the synchronized copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    if (press) begin
      case (state_q)
        LOAD_A: begin
          a_d     = sw_s2_q;
          state_d = LOAD_B;
        end
        LOAD_B: begin
          b_d     = sw_s2_q;
          state_d = LOAD_S;
        end
        LOAD_S: begin
          s_d     = sw_s2_q;
          state_d = SHOW;
        end
        SHOW:    state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
    // Flags are computed from the next state so they change on the same
    // edge as the state register.
    op_valid_d  = (state_d == SHOW);
    load_done_d = press && (state_q == LOAD_S);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      op_valid_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      op_valid_q  <= op_valid_d;
      load_done_q <= load_done_d;
    end
  end

  assign op_valid  = op_valid_q;
  assign load_done = load_done_q;
  assign stage     = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
module tb_alu_operand_loader;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw;
  logic       btn_n;
  logic [2:0] a_q, b_q, s_q;
  logic       op_valid, load_done;
  logic [1:0] stage;

  alu_operand_loader #(
    .WIDTH(3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_n     (btn_n),
    .a_q       (a_q),
    .b_q       (b_q),
    .s_q       (s_q),
    .op_valid  (op_valid),
    .load_done (load_done),
    .stage     (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] s;
    logic [1:0] stage;
    logic       ov;
    logic       ld;
  } exp_t;

  typedef struct {
    logic [2:0] sw;
    int         hold;
    exp_t       exp;
  } vec_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ld_cnt = 0;
  bit   mon_en = 0;
  logic [1:0] prev_stage = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] a, input logic [2:0] b, input logic [2:0] s,
                              input logic [1:0] st, input logic ov, input logic ld);
    exp_t e;
    e.a = a; e.b = b; e.s = s; e.stage = st; e.ov = ov; e.ld = ld;
    return e;
  endfunction

  // Scoreboard: every stage change pops one expected record.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !mon_en) begin
      prev_stage = stage;
    end else begin
      if (load_done === 1'b1) ld_cnt++;
      if (stage !== prev_stage) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_advance: stage %0d, expected to stay at %0d", stage, prev_stage);
        end else begin
          e = sb_q.pop_front();
          check("adv_stage", 32'(stage), 32'(e.stage));
          check("adv_a", 32'(a_q), 32'(e.a));
          check("adv_b", 32'(b_q), 32'(e.b));
          check("adv_s", 32'(s_q), 32'(e.s));
          check("adv_op_valid", 32'(op_valid), 32'(e.ov));
          check("adv_load_done", 32'(load_done), 32'(e.ld));
        end
        prev_stage = stage;
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    check(name, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic do_press(input logic [2:0] swv, input int hold);
    @(negedge clk);
    sw = swv;
    repeat (3) @(negedge clk);
    btn_n = 1'b0;
    repeat (hold) @(negedge clk);
    btn_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_outputs(input string name, input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] s, input logic [1:0] st, input logic ov);
    check({name, "_stage"}, 32'(stage), 32'(st));
    check({name, "_a"}, 32'(a_q), 32'(a));
    check({name, "_b"}, 32'(b_q), 32'(b));
    check({name, "_s"}, 32'(s_q), 32'(s));
    check({name, "_op_valid"}, 32'(op_valid), 32'(ov));
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{sw: 3'd5, hold: 10, exp: mk(3'd5, 3'd0, 3'd0, 2'd1, 1'b0, 1'b0)};
    vecs[1] = '{sw: 3'd3, hold: 10, exp: mk(3'd5, 3'd3, 3'd0, 2'd2, 1'b0, 1'b0)};
    vecs[2] = '{sw: 3'd2, hold: 10, exp: mk(3'd5, 3'd3, 3'd2, 2'd3, 1'b1, 1'b1)};
    vecs[3] = '{sw: 3'd7, hold: 10, exp: mk(3'd5, 3'd3, 3'd2, 2'd0, 1'b0, 1'b0)};
    vecs[4] = '{sw: 3'd7, hold: 10, exp: mk(3'd7, 3'd3, 3'd2, 2'd1, 1'b0, 1'b0)};

    rst_n = 1'b1;
    sw    = 3'd0;
    btn_n = 1'b1;

    // Asynchronous reset asserted mid-cycle.
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("rst_async", 3'd0, 3'd0, 3'd0, 2'd0, 1'b0);
    check("rst_async_load_done", 32'(load_done), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_outputs("rst_idle", 3'd0, 3'd0, 3'd0, 2'd0, 1'b0);
    mon_en = 1'b1;

    // Full load and wrap from the vector table.
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(vecs[i].exp);
      do_press(vecs[i].sw, vecs[i].hold);
      wait_drain($sformatf("vec%0d_drain", i));
    end

    // Bounce rejection: 2-cycle lows never reach the 4-cycle window.
    @(negedge clk);
    sw = 3'd1;
    for (int i = 0; i < 5; i++) begin
      btn_n = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat (2) @(negedge clk);
    end
    btn_n = 1'b1;
    repeat (10) @(negedge clk);
    check_outputs("bounce", 3'd7, 3'd3, 3'd2, 2'd1, 1'b0);
    sb_q.push_back(mk(3'd7, 3'd1, 3'd2, 2'd2, 1'b0, 1'b0));
    do_press(3'd1, 6);
    wait_drain("bounce_clean_drain");

    sb_q.push_back(mk(3'd7, 3'd1, 3'd4, 2'd3, 1'b1, 1'b1));
    do_press(3'd4, 10);
    wait_drain("show2_drain");
    sb_q.push_back(mk(3'd7, 3'd1, 3'd4, 2'd0, 1'b0, 1'b0));
    do_press(3'd0, 10);
    wait_drain("wrap2_drain");

    // Long hold in LOAD_A with the switches changing mid-hold.
    sb_q.push_back(mk(3'd6, 3'd1, 3'd4, 2'd1, 1'b0, 1'b0));
    @(negedge clk);
    sw = 3'd6;
    repeat (3) @(negedge clk);
    btn_n = 1'b0;
    repeat (20) @(negedge clk);
    sw = 3'd1;
    repeat (30) @(negedge clk);
    btn_n = 1'b1;
    repeat (12) @(negedge clk);
    wait_drain("hold_drain");
    check_outputs("hold", 3'd6, 3'd1, 3'd4, 2'd1, 1'b0);

    sb_q.push_back(mk(3'd6, 3'd0, 3'd4, 2'd2, 1'b0, 1'b0));
    do_press(3'd0, 10);
    wait_drain("to_load_s_drain");

    // Reset in LOAD_S while the button is held mid-debounce.
    @(negedge clk);
    sw = 3'd3;
    btn_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("rst_mid", 3'd0, 3'd0, 3'd0, 2'd0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_outputs("rst_held", 3'd0, 3'd0, 3'd0, 2'd0, 1'b0);
    btn_n = 1'b1;
    repeat (15) @(negedge clk);
    sb_q.push_back(mk(3'd5, 3'd0, 3'd0, 2'd1, 1'b0, 1'b0));
    do_press(3'd5, 10);
    wait_drain("repress_drain");

    check("load_done_cycles", 32'(ld_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
